// File: rtl/hour_display_scan.sv
// Multiplexed HH:MM driver for a 4-digit common-cathode 7-segment display.
// It blanks at the start of each slot, snapshots the inputs once per frame, and handles dashes, blinking and leading zero.
module hour_display_scan #(
  parameter int SCAN_DIV     = 1000,
  parameter int BLANK_CYC    = 8,
  parameter int BLINK_FRAMES = 125,
  parameter int LZ_BLANK     = 1
) (
  input  logic       clock,
  input  logic       reset_n,
  input  logic [1:0] hour10,
  input  logic [3:0] hour,
  input  logic [2:0] minute10,
  input  logic [3:0] minute,
  input  logic       colon_en,
  input  logic [1:0] edit_sel,
  output logic [3:0] digit_sel,
  output logic [6:0] seg,
  output logic       dp
);
  localparam int PW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int FW = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
  localparam logic [PW-1:0] P_LAST  = PW'(SCAN_DIV - 1);
  localparam logic [PW-1:0] P_BLANK = PW'(BLANK_CYC);
  localparam logic [FW-1:0] F_LAST  = FW'(BLINK_FRAMES - 1);

  logic [PW-1:0] r_presc;
  logic [1:0]    r_idx;
  logic [FW-1:0] r_frame;
  logic          r_blink;
  logic [1:0]    r_h10;
  logic [3:0]    r_h;
  logic [2:0]    r_m10;
  logic [3:0]    r_m;

  logic       w_h_bad, w_m_bad, w_hours, w_blank, w_blink_off;
  logic [3:0] w_val;
  logic [6:0] w_pat, w_seg;

  function automatic logic [6:0] dec7(input logic [3:0] v);
    case (v)
      4'd0: dec7 = 7'h3F;  4'd1: dec7 = 7'h06;  4'd2: dec7 = 7'h5B;
      4'd3: dec7 = 7'h4F;  4'd4: dec7 = 7'h66;  4'd5: dec7 = 7'h6D;
      4'd6: dec7 = 7'h7D;  4'd7: dec7 = 7'h07;  4'd8: dec7 = 7'h7F;
      4'd9: dec7 = 7'h6F;  default: dec7 = 7'h40;
    endcase
  endfunction

  always_comb begin
    w_h_bad = (r_h10 > 2'd2) || (r_h > 4'd9) || ((r_h10 == 2'd2) && (r_h > 4'd3));
    w_m_bad = (r_m10 > 3'd5) || (r_m > 4'd9);
    w_hours = ~r_idx[1];
    w_blank = (r_presc < P_BLANK);
    w_blink_off = ~r_blink && ((edit_sel_l() == 2'b01 && w_hours) ||
                               (edit_sel_l() == 2'b10 && !w_hours));
    case (r_idx)
      2'd0:    w_val = {2'b00, r_h10};
      2'd1:    w_val = r_h;
      2'd2:    w_val = {1'b0, r_m10};
      default: w_val = r_m;
    endcase
    w_pat = dec7(w_val);
    // Field-level precedence: blink-off beats dash beats leading-zero blank.
    if (w_blink_off)                                     w_seg = 7'h00;
    else if (w_hours ? w_h_bad : w_m_bad)                w_seg = 7'h40;
    else if (LZ_BLANK != 0 && r_idx == 2'd0 && r_h10 == 2'd0) w_seg = 7'h00;
    else                                                 w_seg = w_pat;
  end

  // edit_sel is a live control, not part of the snapshot.
  function automatic logic [1:0] edit_sel_l();
    edit_sel_l = edit_sel;
  endfunction

  always_ff @(negedge clock) begin
    if (!reset_n) begin
      r_presc   <= '0;
      r_idx     <= '0;
      r_frame   <= '0;
      r_blink   <= 1'b1;
      r_h10     <= '0;
      r_h       <= '0;
      r_m10     <= '0;
      r_m       <= '0;
      digit_sel <= '0;
      seg       <= '0;
      dp        <= 1'b0;
    end else begin
      if (r_presc == '0 && r_idx == 2'd0) begin
        r_h10 <= hour10;
        r_h   <= hour;
        r_m10 <= minute10;
        r_m   <= minute;
      end
      if (r_presc == P_LAST) begin
        r_presc <= '0;
        r_idx   <= r_idx + 2'd1;
        if (r_idx == 2'd3) begin
          if (r_frame == F_LAST) begin
            r_frame <= '0;
            r_blink <= ~r_blink;
          end else begin
            r_frame <= r_frame + 1'b1;
          end
        end
      end else begin
        r_presc <= r_presc + 1'b1;
      end
      if (w_blank) begin
        digit_sel <= '0;
        seg       <= '0;
        dp        <= 1'b0;
      end else begin
        digit_sel <= 4'b1000 >> r_idx;
        seg       <= w_seg;
        dp        <= colon_en & r_blink & (r_idx == 2'd1);
      end
    end
  end
endmodule
